// File: rtl/mem_addr_pkg.sv
// Shared types and constants for the memory-address sequencer: FSM states,
// exception cause indices, default vector base and the cause priority encoder.
package mem_addr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VEC  = 3'd1,
    WAIT = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_NO_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVERFLOW  = 2'd1;
  localparam logic [1:0] CAUSE_DIV0      = 2'd2;

  localparam int VEC_BASE_DEFAULT = 253;

  // Wait counter only ever holds MEM_LAT-1, and MEM_LAT is at most 7.
  localparam int CNT_W = 3;

  // Lowest set request bit wins: no_opcode > overflow > div0.
  function automatic logic [1:0] exc_cause_of(input logic [2:0] req);
    logic [1:0] cause;
    if (req[0])      cause = CAUSE_NO_OPCODE;
    else if (req[1]) cause = CAUSE_OVERFLOW;
    else             cause = CAUSE_DIV0;
    return cause;
  endfunction

endpackage

// File: rtl/exc_vec_fsm.sv
// Exception-vector sequencer: latches the cause, drives the vector address,
// waits out the memory read latency and captures the handler byte.
module exc_vec_fsm
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        exc_req_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              idle_o,
  output logic              exc_busy_o,
  output logic              exc_done_o,
  output logic [1:0]        exc_cause_o,
  output logic [ADDR_W-1:0] handler_pc_o,
  output logic [ADDR_W-1:0] vec_addr_o
);

  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] VEC_BASE_W = ADDR_W'(VEC_BASE);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] hpc_q, hpc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      hpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      hpc_q   <= hpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    hpc_d   = hpc_q;
    case (state_q)
      IDLE: begin
        if (|exc_req_i) begin
          cause_d = exc_cause_of(exc_req_i);
          state_d = VEC;
        end
      end
      VEC: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = CAP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CAP: begin
        hpc_d   = {{(ADDR_W-8){1'b0}}, mem_rdata_i};
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests arriving outside IDLE are dropped by construction: only IDLE looks at exc_req_i.
  assign idle_o       = (state_q == IDLE);
  assign exc_busy_o   = (state_q == VEC) || (state_q == WAIT) || (state_q == CAP);
  assign exc_done_o   = (state_q == DONE);
  assign exc_cause_o  = cause_q;
  assign handler_pc_o = hpc_q;
  assign vec_addr_o   = VEC_BASE_W + {{(ADDR_W-2){1'b0}}, cause_q};

endmodule

// File: rtl/mem_addr_seq.sv
// Memory-address select with exception-vector sequencing. Optional PC alignment
// flag is built only when MEM_ADDR_ALIGN_CHECK_EN is defined.
module mem_addr_seq
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int N_SRC    = 4,
  parameter int SEL_W    = 2,
  parameter int MEM_LAT  = 1,
  parameter int VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        addr_sel,
  input  logic [N_SRC*ADDR_W-1:0] src_addr,
  input  logic [2:0]              exc_req,
  input  logic [7:0]              mem_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    exc_busy,
  output logic                    exc_done,
  output logic [1:0]              exc_cause,
  output logic [ADDR_W-1:0]       handler_pc
`ifdef MEM_ADDR_ALIGN_CHECK_EN
  ,
  output logic                    align_fault
`endif
);

  logic              idle;
  logic [ADDR_W-1:0] vec_addr;
  logic [ADDR_W-1:0] src_sel;

  exc_vec_fsm #(
    .ADDR_W  (ADDR_W),
    .MEM_LAT (MEM_LAT),
    .VEC_BASE(VEC_BASE)
  ) u_exc_vec_fsm (
    .clk_i       (clk),
    .rst_i       (reset),
    .exc_req_i   (exc_req),
    .mem_rdata_i (mem_rdata),
    .idle_o      (idle),
    .exc_busy_o  (exc_busy),
    .exc_done_o  (exc_done),
    .exc_cause_o (exc_cause),
    .handler_pc_o(handler_pc),
    .vec_addr_o  (vec_addr)
  );

  // Out-of-range selects read as address 0 rather than an undefined slice.
  always_comb begin
    src_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (addr_sel == SEL_W'(i)) src_sel = src_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign mem_addr = idle ? src_sel : vec_addr;

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  logic align_fault_q, align_fault_d;

  // Informational only: the misaligned PC still reaches mem_addr.
  assign align_fault_d = idle && (addr_sel == '0) && (src_sel[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) align_fault_q <= 1'b0;
    else       align_fault_q <= align_fault_d;
  end

  assign align_fault = align_fault_q;
`endif

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq: two instances (4 sources/latency 1, 3 sources/latency 3)
// checked every cycle against a cycle-count reference model.
module tb_mem_addr_seq;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]  a_srcs [4];
  logic [127:0] a_src;
  logic [1:0]   a_sel;
  logic [2:0]   a_req;
  logic [7:0]   a_rdata;
  logic [31:0]  a_addr, a_hpc;
  logic         a_busy, a_done, a_flt;
  logic [1:0]   a_cause;

  logic [31:0]  b_srcs [3];
  logic [95:0]  b_src;
  logic [1:0]   b_sel;
  logic [2:0]   b_req;
  logic [7:0]   b_rdata;
  logic [31:0]  b_addr, b_hpc;
  logic         b_busy, b_done, b_flt;
  logic [1:0]   b_cause;

  assign a_src = {a_srcs[3], a_srcs[2], a_srcs[1], a_srcs[0]};
  assign b_src = {b_srcs[2], b_srcs[1], b_srcs[0]};

  mem_addr_seq #(.ADDR_W(32), .N_SRC(4), .SEL_W(2), .MEM_LAT(LAT_A), .VEC_BASE(253)) dut_a (
    .clk(clk), .reset(rst), .addr_sel(a_sel), .src_addr(a_src), .exc_req(a_req),
    .mem_rdata(a_rdata), .mem_addr(a_addr), .exc_busy(a_busy), .exc_done(a_done),
    .exc_cause(a_cause), .handler_pc(a_hpc)
`ifdef MEM_ADDR_ALIGN_CHECK_EN
    , .align_fault(a_flt)
`endif
  );

  mem_addr_seq #(.ADDR_W(32), .N_SRC(3), .SEL_W(2), .MEM_LAT(LAT_B), .VEC_BASE(253)) dut_b (
    .clk(clk), .reset(rst), .addr_sel(b_sel), .src_addr(b_src), .exc_req(b_req),
    .mem_rdata(b_rdata), .mem_addr(b_addr), .exc_busy(b_busy), .exc_done(b_done),
    .exc_cause(b_cause), .handler_pc(b_hpc)
`ifdef MEM_ADDR_ALIGN_CHECK_EN
    , .align_fault(b_flt)
`endif
  );

`ifndef MEM_ADDR_ALIGN_CHECK_EN
  assign a_flt = 1'b0;
  assign b_flt = 1'b0;
`endif

  // Reference model: ph counts cycles since the request was taken
  // (0 idle, 1 vector issue, then LAT wait cycles, capture, done).
  function automatic logic [1:0] first_cause(input logic [2:0] req);
    for (int i = 0; i < 3; i++) if (req[i]) return 2'(i);
    return 2'd0;
  endfunction

  int          ma_ph = 0, mb_ph = 0;
  logic [1:0]  ma_cause = 0, mb_cause = 0;
  logic [31:0] ma_hpc = 0, mb_hpc = 0;
  logic        ma_flt = 0;

  always @(posedge clk) begin
    if (rst) begin
      ma_ph <= 0; ma_cause <= 2'd0; ma_hpc <= 32'd0; ma_flt <= 1'b0;
    end else begin
      ma_flt <= (ma_ph == 0) && (a_sel == 2'd0) && (a_srcs[0][1:0] != 2'b00);
      if (ma_ph == 0) begin
        if (a_req != 3'b000) begin
          ma_cause <= first_cause(a_req);
          ma_ph    <= 1;
        end
      end else if (ma_ph >= LAT_A + 3) begin
        ma_ph <= 0;
      end else begin
        if (ma_ph == LAT_A + 2) ma_hpc <= {24'h0, a_rdata};
        ma_ph <= ma_ph + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      mb_ph <= 0; mb_cause <= 2'd0; mb_hpc <= 32'd0;
    end else begin
      if (mb_ph == 0) begin
        if (b_req != 3'b000) begin
          mb_cause <= first_cause(b_req);
          mb_ph    <= 1;
        end
      end else if (mb_ph >= LAT_B + 3) begin
        mb_ph <= 0;
      end else begin
        if (mb_ph == LAT_B + 2) mb_hpc <= {24'h0, b_rdata};
        mb_ph <= mb_ph + 1;
      end
    end
  end

  function automatic logic [67:0] exp_a();
    logic [31:0] addr;
    if (ma_ph == 0) addr = (a_sel < 2'd3 || a_sel == 2'd3) ? a_srcs[a_sel] : 32'd0;
    else            addr = 32'd253 + 32'(ma_cause);
    return {addr, (ma_ph >= 1 && ma_ph <= LAT_A + 2), (ma_ph == LAT_A + 3), ma_cause, ma_hpc};
  endfunction

  function automatic logic [67:0] exp_b();
    logic [31:0] addr;
    if (mb_ph == 0) addr = (b_sel < 2'd3) ? b_srcs[b_sel] : 32'd0;
    else            addr = 32'd253 + 32'(mb_cause);
    return {addr, (mb_ph >= 1 && mb_ph <= LAT_B + 2), (mb_ph == LAT_B + 3), mb_cause, mb_hpc};
  endfunction

  function automatic logic [67:0] obs_a();
    return {a_addr, a_busy, a_done, a_cause, a_hpc};
  endfunction

  function automatic logic [67:0] obs_b();
    return {b_addr, b_busy, b_done, b_cause, b_hpc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_req = 3'b111; b_req = 3'b101;
    tick();
    tick();
    a_req = 3'b000; b_req = 3'b000;
    #1;
    checks++;
    if ({a_busy, a_done, a_cause, a_hpc} !== 36'd0)
      $display("FAIL reset_a actual=%h required=0", {a_busy, a_done, a_cause, a_hpc});
    checks++;
    if ({b_busy, b_done, b_cause, b_hpc} !== 36'd0)
      $display("FAIL reset_b actual=%h required=0", {b_busy, b_done, b_cause, b_hpc});
    checks++;
    if (a_flt !== 1'b0) $display("FAIL reset_align actual=%b required=0", a_flt);
    if ({a_busy, a_done, a_cause, a_hpc} !== 36'd0) errors++;
    if ({b_busy, b_done, b_cause, b_hpc} !== 36'd0) errors++;
    if (a_flt !== 1'b0) errors++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mux();
    a_srcs[0] = 32'h10; a_srcs[1] = 32'h20; a_srcs[2] = 32'h30; a_srcs[3] = 32'h40;
    b_srcs[0] = 32'h10; b_srcs[1] = 32'h20; b_srcs[2] = 32'h30;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      #1;
      checks++;
      if (a_addr !== 32'h10 * 32'(s + 1)) begin
        errors++;
        $display("FAIL mux_a sel=%0d actual=%h required=%h", s, a_addr, 32'h10 * 32'(s + 1));
      end
    end
    b_sel = 2'd3;
    #1;
    checks++;
    if (b_addr !== 32'd0) begin
      errors++;
      $display("FAIL mux_b_out_of_range actual=%h required=0", b_addr);
    end
    b_sel = 2'd2;
    #1;
    checks++;
    if (b_addr !== 32'h30) begin
      errors++;
      $display("FAIL mux_b_sel2 actual=%h required=30", b_addr);
    end
    tick();
  endtask

  task automatic test_exc_seq();
    int done_at;
    done_at = -1;
    a_sel = 2'd1; a_req = 3'b010; a_rdata = 8'h00;
    #1;
    checks++;
    if (obs_a() !== exp_a()) begin
      errors++;
      $display("FAIL exc_seq_c0 actual=%h required=%h", obs_a(), exp_a());
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      a_rdata = (c == 3) ? 8'h5C : 8'(8'hA0 + c);
      if (c == 4) a_req = 3'b000;
      #1;
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++;
        $display("FAIL exc_seq_cycle c=%0d actual=%h required=%h", c, obs_a(), exp_a());
      end
      if (a_done === 1'b1) done_at = c;
      if (c <= 2) begin
        checks++;
        if (a_addr !== 32'd254) begin
          errors++;
          $display("FAIL exc_seq_vector c=%0d actual=%0d required=254", c, a_addr);
        end
      end
    end
    checks++;
    if (done_at != 4) begin
      errors++;
      $display("FAIL exc_seq_done_latency actual=%0d required=4", done_at);
    end
    checks++;
    if (a_hpc !== 32'h5C || a_cause !== 2'd1) begin
      errors++;
      $display("FAIL exc_seq_capture actual=%h/%0d required=5c/1", a_hpc, a_cause);
    end
  endtask

  task automatic test_priority();
    logic [2:0]  reqs [2];
    logic [31:0] vecs [2];
    logic [1:0]  causes [2];
    reqs[0] = 3'b111; vecs[0] = 32'd253; causes[0] = 2'd0;
    reqs[1] = 3'b100; vecs[1] = 32'd255; causes[1] = 2'd2;
    for (int t = 0; t < 2; t++) begin
      a_req = reqs[t];
      for (int c = 1; c <= 5; c++) begin
        tick();
        a_rdata = 8'($urandom_range(0, 255));
        if (c == 4) a_req = 3'b000;
        #1;
        checks++;
        if (obs_a() !== exp_a()) begin
          errors++;
          $display("FAIL priority_cycle t=%0d c=%0d actual=%h required=%h", t, c, obs_a(), exp_a());
        end
        if (c == 1) begin
          checks++;
          if (a_addr !== vecs[t] || a_cause !== causes[t]) begin
            errors++;
            $display("FAIL priority_vector t=%0d actual=%0d/%0d required=%0d/%0d",
                     t, a_addr, a_cause, vecs[t], causes[t]);
          end
        end
      end
    end
  endtask

  task automatic test_lat3();
    int done_cnt, vec_cnt;
    done_cnt = 0; vec_cnt = 0;
    b_sel = 2'd0; b_req = 3'b001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      b_rdata = (c == 5) ? 8'hA7 : 8'(8'h10 + c);
      if (c == 3) b_req = 3'b010;
      if (c == 6) b_req = 3'b000;
      #1;
      checks++;
      if (obs_b() !== exp_b()) begin
        errors++;
        $display("FAIL lat3_cycle c=%0d actual=%h required=%h", c, obs_b(), exp_b());
      end
      if (b_done === 1'b1) done_cnt++;
      if (c <= 4 && b_addr === 32'd253 && b_busy === 1'b1) vec_cnt++;
    end
    checks++;
    if (vec_cnt != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL lat3_hold actual=vec%0d/done%0d required=vec4/done1", vec_cnt, done_cnt);
    end
    checks++;
    if (b_hpc !== 32'hA7 || b_cause !== 2'd0) begin
      errors++;
      $display("FAIL lat3_capture actual=%h/%0d required=a7/0", b_hpc, b_cause);
    end
  endtask

  task automatic test_reset_in_wait();
    b_srcs[1] = 32'h0000_BEE0; b_sel = 2'd1; b_req = 3'b100;
    tick();
    tick();
    #1;
    checks++;
    if (b_busy !== 1'b1 || b_addr !== 32'd255) begin
      errors++;
      $display("FAIL rst_wait_pre actual=%b/%0d required=1/255", b_busy, b_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; b_req = 3'b000;
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_hpc !== 32'd0 || b_addr !== 32'h0000_BEE0) begin
      errors++;
      $display("FAIL rst_wait_post actual=%b/%h/%h required=0/0/0000bee0", b_busy, b_hpc, b_addr);
    end
    checks++;
    if (obs_b() !== exp_b()) begin
      errors++;
      $display("FAIL rst_wait_model actual=%h required=%h", obs_b(), exp_b());
    end
    tick();
  endtask

  task automatic test_align();
`ifdef MEM_ADDR_ALIGN_CHECK_EN
    logic [31:0] pcs  [3];
    logic [1:0]  sels [3];
    logic        want [3];
    pcs[0] = 32'h1002; sels[0] = 2'd0; want[0] = 1'b1;
    pcs[1] = 32'h1004; sels[1] = 2'd0; want[1] = 1'b0;
    pcs[2] = 32'h1003; sels[2] = 2'd2; want[2] = 1'b0;
    a_req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a_srcs[0] = pcs[i]; a_sel = sels[i];
      #1;
      checks++;
      if (a_sel == 2'd0 && a_addr !== pcs[i]) begin
        errors++;
        $display("FAIL align_passthru i=%0d actual=%h required=%h", i, a_addr, pcs[i]);
      end
      tick();
      checks++;
      if (a_flt !== want[i]) begin
        errors++;
        $display("FAIL align_fault i=%0d actual=%b required=%b", i, a_flt, want[i]);
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick();
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) a_srcs[i] = $urandom;
      for (int i = 0; i < 3; i++) b_srcs[i] = $urandom;
      a_sel = 2'($urandom_range(0, 3));
      b_sel = 2'($urandom_range(0, 3));
      a_req = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      b_req = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      a_rdata = 8'($urandom_range(0, 255));
      b_rdata = 8'($urandom_range(0, 255));
      #1;
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++;
        $display("FAIL random_a n=%0d actual=%h required=%h", n, obs_a(), exp_a());
      end
      checks++;
      if (obs_b() !== exp_b()) begin
        errors++;
        $display("FAIL random_b n=%0d actual=%h required=%h", n, obs_b(), exp_b());
      end
`ifdef MEM_ADDR_ALIGN_CHECK_EN
      checks++;
      if (a_flt !== ma_flt) begin
        errors++;
        $display("FAIL random_align n=%0d actual=%b required=%b", n, a_flt, ma_flt);
      end
`endif
    end
    rst = 1'b0; a_req = 3'b000; b_req = 3'b000;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) a_srcs[i] = 32'd0;
    for (int i = 0; i < 3; i++) b_srcs[i] = 32'd0;
    a_sel = 2'd0; b_sel = 2'd0;
    a_req = 3'b000; b_req = 3'b000;
    a_rdata = 8'd0; b_rdata = 8'd0;
    test_reset();
    test_mux();
    test_exc_seq();
    test_priority();
    test_lat3();
    test_reset_in_wait();
    test_align();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
